// File: rtl/llki_discrete_master.sv
// LLKI discrete master: takes a key command, reads the key words from the key
// store and hands them one at a time to an LLKI discrete slave over a 4-phase
// req/ack handshake. The outcome (OK, slave error, timeout or bad op) is
// reported with a single-cycle response pulse.
module llki_discrete_master #(
  parameter int KEY_WORDS   = 2,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  output logic                  key_rd_en,
  output logic [((KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1)-1:0] key_rd_addr,
  input  logic [DATA_W-1:0]     key_rd_data,
  output logic                  llki_req,
  output logic [1:0]            llki_op,
  output logic [DATA_W-1:0]     llki_data,
  output logic                  llki_last,
  input  logic                  llki_ack,
  input  logic                  llki_err,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic                  busy,
  output logic                  key_loaded
);

  localparam int AW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(KEY_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  // Command encodings on cmd_op and the op code carried on llki_op
  localparam logic [1:0] CMD_LOAD  = 2'd0;
  localparam logic [1:0] CMD_CLEAR = 2'd1;
  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_LOAD   = 2'd1;
  localparam logic [1:0] OP_CLEAR  = 2'd2;

  // Response status codes
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_SLV_ERR = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BAD_OP  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [AW-1:0]      r_idx;
  logic [DATA_W-1:0]  r_data;
  logic               r_last;
  logic [1:0]         r_op;
  logic               r_err;
  logic [TW-1:0]      r_timer;
  logic [1:0]         r_status;
  logic               r_key_loaded;
  logic               r_ready_en;

  logic               w_accept;
  logic               w_done;
  logic [1:0]         w_status_next;
  logic               w_timer_clr;
  logic               w_ack_seen;
  logic               w_advance;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the strobes that steer the datapath below
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    w_status_next = ST_OK;
    w_timer_clr   = 1'b0;
    w_ack_seen    = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_accept = 1'b1;
          if (cmd_op == CMD_LOAD) begin
            w_state_next = S_FETCH;
          end else if (cmd_op == CMD_CLEAR) begin
            w_state_next = S_SEND;
            w_timer_clr  = 1'b1;
          end else begin
            w_state_next  = S_DONE;
            w_done        = 1'b1;
            w_status_next = ST_BAD_OP;
          end
        end
      end
      S_FETCH: begin
        w_state_next = S_LATCH;
      end
      S_LATCH: begin
        w_state_next = S_SEND;
        w_timer_clr  = 1'b1;
      end
      S_SEND: begin
        if (llki_ack) begin
          w_state_next = S_GAP;
          w_timer_clr  = 1'b1;
          w_ack_seen   = 1'b1;
        end else if (r_timer == TMO_LAST) begin
          w_state_next  = S_DONE;
          w_done        = 1'b1;
          w_status_next = ST_TIMEOUT;
        end
      end
      S_GAP: begin
        if (!llki_ack) begin
          if (r_err) begin
            w_state_next  = S_DONE;
            w_done        = 1'b1;
            w_status_next = ST_SLV_ERR;
          end else if (r_last) begin
            w_state_next  = S_DONE;
            w_done        = 1'b1;
            w_status_next = ST_OK;
          end else begin
            w_state_next = S_FETCH;
            w_advance    = 1'b1;
          end
        end else if (r_timer == TMO_LAST) begin
          w_state_next  = S_DONE;
          w_done        = 1'b1;
          w_status_next = ST_TIMEOUT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Transfer datapath: word index, held word/op/last, error latch, ack timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_op    <= OP_NONE;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      if (w_accept) begin
        r_idx <= '0;
        r_err <= 1'b0;
        if (cmd_op == CMD_LOAD) begin
          r_op <= OP_LOAD;
        end else if (cmd_op == CMD_CLEAR) begin
          r_op   <= OP_CLEAR;
          r_data <= '0;
          r_last <= 1'b1;
        end else begin
          r_op <= OP_NONE;
        end
      end
      if (r_state == S_LATCH) begin
        r_data <= key_rd_data;
        r_last <= (r_idx == LAST_IDX);
      end
      if (w_ack_seen) begin
        r_err <= llki_err;
      end
      if (w_advance) begin
        r_idx <= r_idx + AW'(1);
      end
      if (w_timer_clr) begin
        r_timer <= '0;
      end else if (r_state == S_SEND || r_state == S_GAP) begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // Completion bookkeeping: response status and the key-loaded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status     <= ST_OK;
      r_key_loaded <= 1'b0;
    end else if (w_done) begin
      r_status <= w_status_next;
      if (w_status_next == ST_OK) begin
        if (r_op == OP_LOAD) begin
          r_key_loaded <= 1'b1;
        end else if (r_op == OP_CLEAR) begin
          r_key_loaded <= 1'b0;
        end
      end else if ((w_status_next == ST_SLV_ERR || w_status_next == ST_TIMEOUT) &&
                   r_op == OP_LOAD) begin
        r_key_loaded <= 1'b0;
      end
    end
  end

  // Keeps cmd_ready low while reset is applied so every output reads 0 then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  assign cmd_ready   = r_ready_en && (r_state == S_IDLE) && !llki_ack;
  assign key_rd_en   = (r_state == S_FETCH);
  assign key_rd_addr = r_idx;
  assign llki_req    = (r_state == S_SEND);
  assign llki_op     = r_op;
  assign llki_data   = r_data;
  assign llki_last   = r_last;
  assign rsp_valid   = (r_state == S_DONE);
  assign rsp_status  = r_status;
  assign busy        = (r_state != S_IDLE);
  assign key_loaded  = r_key_loaded;

endmodule

// File: tb/tb_llki_discrete_master.sv
// Directed bench for llki_discrete_master with a key-store model, a reactive
// LLKI slave model and a handshake protocol monitor.
module tb_llki_discrete_master;

  localparam int KW = 2;
  localparam int DW = 64;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          key_rd_en;
  logic [0:0]    key_rd_addr;
  logic [DW-1:0] key_rd_data = '0;
  logic          llki_req;
  logic [1:0]    llki_op;
  logic [DW-1:0] llki_data;
  logic          llki_last;
  logic          llki_ack;
  logic          llki_err;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic          busy;
  logic          key_loaded;

  int n_vec = 0;
  int n_miss = 0;

  // Slave model controls
  logic          s_ack, s_err;
  int            s_cnt;
  int            s_delay = 3;
  int            s_err_word = -1;
  logic          s_silent = 1'b0;
  logic          m_man = 1'b0;
  logic          m_ack = 1'b0;

  logic [DW-1:0] key_mem [KW];
  logic [DW-1:0] cap_data[$];
  logic          cap_last[$];
  logic [1:0]    cap_op[$];
  logic [0:0]    rd_addrs[$];

  // Protocol monitor state
  logic          p_req = 1'b0;
  logic [DW-1:0] p_data = '0;
  logic [1:0]    p_op = '0;
  logic          p_last = 1'b0;
  logic          stable = 1'b1;

  assign llki_ack = m_man ? m_ack : s_ack;
  assign llki_err = m_man ? 1'b0 : s_err;

  always #5 clk = ~clk;

  llki_discrete_master #(
    .KEY_WORDS  (KW),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .key_rd_en  (key_rd_en),
    .key_rd_addr(key_rd_addr),
    .key_rd_data(key_rd_data),
    .llki_req   (llki_req),
    .llki_op    (llki_op),
    .llki_data  (llki_data),
    .llki_last  (llki_last),
    .llki_ack   (llki_ack),
    .llki_err   (llki_err),
    .rsp_valid  (rsp_valid),
    .rsp_status (rsp_status),
    .busy       (busy),
    .key_loaded (key_loaded)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Key store: one-cycle read latency
  always @(posedge clk) begin
    if (key_rd_en) begin
      key_rd_data <= key_mem[key_rd_addr];
      rd_addrs.push_back(key_rd_addr);
    end
  end

  // Slave: acks s_delay cycles after seeing req, drops ack after req drops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      s_cnt <= 0;
    end else if (llki_req && !s_ack && !s_silent) begin
      if (s_cnt >= s_delay - 1) begin
        s_ack <= 1'b1;
        s_err <= (cap_data.size() == s_err_word);
        s_cnt <= 0;
        cap_data.push_back(llki_data);
        cap_last.push_back(llki_last);
        cap_op.push_back(llki_op);
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end else if (!llki_req && s_ack) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
    end
  end

  // Protocol monitor: no req rise with ack high; payload stable while req high
  always @(negedge clk) begin
    if (llki_req && !p_req) begin
      check("req_rise_with_ack", {63'd0, llki_ack}, 64'd0);
    end
    if (llki_req && p_req &&
        (llki_data !== p_data || llki_op !== p_op || llki_last !== p_last)) begin
      stable <= 1'b0;
    end
    if (!llki_req && p_req) begin
      check("payload_stable", {63'd0, stable}, 64'd1);
      stable <= 1'b1;
    end
    p_req  <= llki_req;
    p_data <= llki_data;
    p_op   <= llki_op;
    p_last <= llki_last;
  end

  task automatic clear_caps();
    cap_data.delete();
    cap_last.delete();
    cap_op.delete();
    rd_addrs.delete();
  endtask

  // Present one command as soon as cmd_ready allows; returns just after the accept edge
  task automatic issue(input logic [1:0] op);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for the response pulse and report it
  task automatic wait_rsp(output logic [1:0] st);
    int t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rsp_seen", {63'd0, rsp_valid}, 64'd1);
    st = rsp_status;
    $display("rsp: status=%0d key_loaded=%0d words_acked=%0d", rsp_status, key_loaded,
             cap_data.size());
  endtask

  initial begin
    logic [1:0] st;
    int cnt;
    int t;

    key_mem[0] = 64'hA5A5_A5A5_A5A5_A501;
    key_mem[1] = 64'h5A5A_5A5A_5A5A_5A02;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_req", {63'd0, llki_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_key_loaded", {63'd0, key_loaded}, 64'd0);
    check("rst_rd_en", {63'd0, key_rd_en}, 64'd0);
    check("rst_data", llki_data, 64'd0);
    check("rst_misc", {58'd0, llki_op, rsp_status, llki_last, key_rd_addr}, 64'd0);
    rst_n = 1'b1;

    // 1: LOAD, slave acks after 3 cycles
    clear_caps();
    issue(2'd0);
    @(negedge clk);
    check("t1_fetch_rd_en", {63'd0, key_rd_en}, 64'd1);
    check("t1_fetch_req", {63'd0, llki_req}, 64'd0);
    check("t1_fetch_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("t1_latch_req", {63'd0, llki_req}, 64'd0);
    @(negedge clk);
    check("t1_req_2cyc", {63'd0, llki_req}, 64'd1);
    wait_rsp(st);
    check("t1_status", {62'd0, st}, 64'd0);
    check("t1_key_loaded", {63'd0, key_loaded}, 64'd1);
    check("t1_nwords", cap_data.size(), 2);
    check("t1_word0", cap_data[0], 64'hA5A5_A5A5_A5A5_A501);
    check("t1_word1", cap_data[1], 64'h5A5A_5A5A_5A5A_5A02);
    check("t1_last", {62'd0, cap_last[0], cap_last[1]}, 64'd1);
    check("t1_op", {60'd0, cap_op[0], cap_op[1]}, 64'h5);
    check("t1_addrs", {62'd0, rd_addrs[0], rd_addrs[1]}, 64'd1);
    @(negedge clk);
    check("t1_rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);

    // 4: illegal op, key_loaded stays 1
    clear_caps();
    issue(2'd3);
    @(negedge clk);
    check("t4_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check("t4_status", {62'd0, rsp_status}, 64'd3);
    check("t4_req", {63'd0, llki_req}, 64'd0);
    check("t4_key_loaded", {63'd0, key_loaded}, 64'd1);
    $display("rsp: status=%0d key_loaded=%0d (bad op)", rsp_status, key_loaded);
    @(negedge clk);
    check("t4_rsp_drop", {63'd0, rsp_valid}, 64'd0);
    check("t4_status_held", {62'd0, rsp_status}, 64'd3);
    check("t4_no_words", cap_data.size(), 0);

    // 3: CLEAR against a silent slave -> timeout after 8 req cycles
    clear_caps();
    s_silent = 1'b1;
    issue(2'd1);
    cnt = 0;
    t = 0;
    @(negedge clk);
    while (!rsp_valid && t < 50) begin
      if (llki_req) cnt++;
      @(negedge clk);
      t++;
    end
    check("t3_rsp_seen", {63'd0, rsp_valid}, 64'd1);
    check("t3_req_cycles", cnt, 8);
    check("t3_status", {62'd0, rsp_status}, 64'd2);
    check("t3_key_loaded_kept", {63'd0, key_loaded}, 64'd1);
    $display("rsp: status=%0d req_cycles=%0d (timeout)", rsp_status, cnt);
    s_silent = 1'b0;
    m_man = 1'b1;
    m_ack = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    repeat (3) @(negedge clk);
    check("t3_late_ack_ready", {63'd0, cmd_ready}, 64'd0);
    check("t3_late_ack_busy", {63'd0, busy}, 64'd0);
    check("t3_late_ack_req", {63'd0, llki_req}, 64'd0);
    cmd_valid = 1'b0;
    m_ack = 1'b0;
    #1;
    check("t3_ready_after_ack", {63'd0, cmd_ready}, 64'd1);
    m_man = 1'b0;

    // 2: LOAD with error on the first word
    clear_caps();
    s_err_word = 0;
    issue(2'd0);
    wait_rsp(st);
    check("t2_status", {62'd0, st}, 64'd1);
    check("t2_nwords", cap_data.size(), 1);
    check("t2_key_loaded", {63'd0, key_loaded}, 64'd0);
    s_err_word = -1;

    // 5: reset during the second word's SEND
    issue(2'd0);
    wait_rsp(st);
    check("t5_pre_load", {63'd0, key_loaded}, 64'd1);
    clear_caps();
    s_delay = 6;
    issue(2'd0);
    t = 0;
    @(negedge clk);
    while (!(llki_req && cap_data.size() == 1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t5_word2_send", {63'd0, llki_req}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_req", {63'd0, llki_req}, 64'd0);
    check("t5_async_busy", {63'd0, busy}, 64'd0);
    check("t5_async_rsp", {63'd0, rsp_valid}, 64'd0);
    check("t5_async_kl", {63'd0, key_loaded}, 64'd0);
    $display("reset applied mid-command");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_delay = 3;
    clear_caps();
    issue(2'd0);
    wait_rsp(st);
    check("t5_restart_status", {62'd0, st}, 64'd0);
    check("t5_restart_idx0", {63'd0, rd_addrs[0]}, 64'd0);
    check("t5_restart_word0", cap_data[0], 64'hA5A5_A5A5_A5A5_A501);

    // 6: back-to-back LOAD then CLEAR
    key_mem[0] = 64'h0123_4567_89AB_CDEF;
    key_mem[1] = 64'hFEDC_BA98_7654_3210;
    clear_caps();
    issue(2'd0);
    wait_rsp(st);
    check("t6_load_status", {62'd0, st}, 64'd0);
    check("t6_load_kl", {63'd0, key_loaded}, 64'd1);
    check("t6_word1", cap_data[1], 64'hFEDC_BA98_7654_3210);
    clear_caps();
    issue(2'd1);
    @(negedge clk);
    check("t6_clear_req_1cyc", {63'd0, llki_req}, 64'd1);
    wait_rsp(st);
    check("t6_clear_status", {62'd0, st}, 64'd0);
    check("t6_clear_kl", {63'd0, key_loaded}, 64'd0);
    check("t6_clear_nwords", cap_data.size(), 1);
    check("t6_clear_data", cap_data[0], 64'd0);
    check("t6_clear_last_op", {61'd0, cap_last[0], cap_op[0]}, 64'h6);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
